vga_dither_output: RTL and testbench

Output stage of the VGA playground pipeline, downstream of the noise/colour generator. It takes 6-bit-per-channel colour and the raw sync/position signals, and delays sync and position to line up with the colour pipeline latency. It applies a temporally toggled 8x4 Bayer ordered dither down to 2 bits per channel. It registers the result onto the TinyVGA PMOD pinout and also owns the frame counter that drives animation upstream.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_dither_output_if.sv | 29 ++
 rtl/vga_sync_delay.sv | 34 +++
 rtl/vga_dither_output.sv | 94 +++++++++
 tb/tb_vga_dither_output.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and pixel arithmetic for the VGA output stage:
// PMOD bit positions, the 8x4 Bayer index and the 6-to-2 bit dither.
package vga_pkg;

    localparam int COLOR_W = 6;

    // TinyVGA PMOD pinout: {hsync, B0, G0, R0, vsync, B1, G1, R1}
    localparam int PMOD_R1    = 0;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_HSYNC = 7;

    // Width of the aligned bundle {hsync, vsync, display_on, hpos[2:0], vpos[1:0]}
    localparam int SYNC_W = 8;

    function automatic logic [4:0] bayer5(input logic [2:0] hpos3,
                                          input logic [1:0] vpos2,
                                          input logic       parity);
        logic [2:0] i;
        logic [2:0] x;
        i = hpos3 ^ {3{parity}};
        x = {i[2], i[1] ^ vpos2[1], i[0] ^ vpos2[0]};
        return {x[0], i[0], x[1], i[1], x[2]};
    endfunction

    // Sum tops out at 127, so the top two bits are the rounded 2-bit level.
    function automatic logic [1:0] dither2(input logic [5:0] color6,
                                           input logic [4:0] bayer);
        logic [6:0] s;
        s = 7'(color6) + 7'(bayer) + 7'(color6[0]) + 7'(color6[5]) + 7'(color6[5:1]);
        return s[6:5];
    endfunction

endpackage

// File: rtl/vga_dither_output_if.sv
// Pixel-stream bundle between the colour generator (master) and the
// dither/output stage (slave), including the frame count fed back upstream.
interface vga_dither_output_if #(
    parameter int FRAME_W = 11
);
    logic               hsync_in;
    logic               vsync_in;
    logic               display_on_in;
    logic [2:0]         hpos_in;
    logic [1:0]         vpos_in;
    logic [5:0]         r_in;
    logic [5:0]         g_in;
    logic [5:0]         b_in;
    logic               dither_en;
    logic [7:0]         uo_out;
    logic [FRAME_W-1:0] frame;

    modport master (
        output hsync_in, vsync_in, display_on_in, hpos_in, vpos_in,
        output r_in, g_in, b_in, dither_en,
        input  uo_out, frame
    );

    modport slave (
        input  hsync_in, vsync_in, display_on_in, hpos_in, vpos_in,
        input  r_in, g_in, b_in, dither_en,
        output uo_out, frame
    );
endinterface

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register with synchronous active-low clear; depth 0
// collapses to a wire so the caller needs no special case.
module vga_sync_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    if (DEPTH == 0) begin : g_bypass
        assign o_data = i_data;
    end else begin : g_pipe
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] r_q;
            logic [WIDTH-1:0] w_d;

            if (gi == 0) begin : g_first
                assign w_d = i_data;
            end else begin : g_next
                assign w_d = g_stage[gi-1].r_q;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) r_q <= '0;
                else        r_q <= w_d;
            end
        end
        assign o_data = g_stage[DEPTH-1].r_q;
    end

endmodule

// File: rtl/vga_dither_output.sv
// VGA output stage: aligns sync/position with the colour pipeline, applies a
// frame-toggled Bayer dither to 2 bits/channel and registers the PMOD pins.
module vga_dither_output #(
    parameter int COLOR_W    = 6,
    parameter int PIPE_DELAY = 2,
    parameter int FRAME_W    = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_dither_output_if.slave   bus
);
    import vga_pkg::*;

    logic [SYNC_W-1:0]  w_sync_in;
    logic [SYNC_W-1:0]  w_sync_d;
    logic               w_hsync_d;
    logic               w_vsync_d;
    logic               w_display_on_d;
    logic [2:0]         w_hpos_d;
    logic [1:0]         w_vpos_d;
    logic [4:0]         w_bayer;
    logic [COLOR_W-1:0] w_color [3];
    logic [1:0]         w_level [3];
    logic [7:0]         w_uo_next;

    logic               r_vsync_q;
    logic [FRAME_W-1:0] r_frame;
    logic [7:0]         r_uo;

    assign w_sync_in = {bus.hsync_in, bus.vsync_in, bus.display_on_in,
                        bus.hpos_in, bus.vpos_in};

    vga_sync_delay #(
        .WIDTH (SYNC_W),
        .DEPTH (PIPE_DELAY)
    ) u_align (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_sync_in),
        .o_data (w_sync_d)
    );

    assign {w_hsync_d, w_vsync_d, w_display_on_d, w_hpos_d, w_vpos_d} = w_sync_d;

    // Cleared r_vsync_q makes a vsync_d already high after reset count as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vsync_q <= 1'b0;
            r_frame   <= '0;
        end else begin
            r_vsync_q <= w_vsync_d;
            if (w_vsync_d && !r_vsync_q)
                r_frame <= r_frame + 1'b1;
        end
    end

    // Registered frame[0]: the edge-cycle pixel still sees the old parity.
    assign w_bayer = bayer5(w_hpos_d, w_vpos_d, r_frame[0]);

    assign w_color[0] = bus.r_in;
    assign w_color[1] = bus.g_in;
    assign w_color[2] = bus.b_in;

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        always_comb begin
            w_level[gi] = 2'b00;
            if (w_display_on_d) begin
                if (bus.dither_en) w_level[gi] = dither2(w_color[gi], w_bayer);
                else               w_level[gi] = w_color[gi][COLOR_W-1:COLOR_W-2];
            end
        end
    end

    always_comb begin
        w_uo_next             = 8'h00;
        w_uo_next[PMOD_HSYNC] = w_hsync_d;
        w_uo_next[PMOD_VSYNC] = w_vsync_d;
        w_uo_next[PMOD_R0]    = w_level[0][0];
        w_uo_next[PMOD_G0]    = w_level[1][0];
        w_uo_next[PMOD_B0]    = w_level[2][0];
        w_uo_next[PMOD_R1]    = w_level[0][1];
        w_uo_next[PMOD_G1]    = w_level[1][1];
        w_uo_next[PMOD_B1]    = w_level[2][1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_uo <= 8'h00;
        else        r_uo <= w_uo_next;
    end

    assign bus.uo_out = r_uo;
    assign bus.frame  = r_frame;

endmodule

// File: tb/tb_vga_dither_output.sv
// Self-checking bench for vga_dither_output: a cycle model pushes expected
// pin/frame values per clock and a negedge monitor pops and compares them.
module tb_vga_dither_output;

    localparam int PIPE_DELAY = 2;
    localparam int FRAME_W    = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_dither_output_if #(.FRAME_W(FRAME_W)) bus ();

    vga_dither_output #(
        .COLOR_W    (6),
        .PIPE_DELAY (PIPE_DELAY),
        .FRAME_W    (FRAME_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]         uo;
        logic [FRAME_W-1:0] frame;
        string              tag;
    } exp_t;

    exp_t               sb_q[$];
    logic [7:0]         m_hist[$];
    logic               m_vsync_q;
    logic [FRAME_W-1:0] m_frame;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_bayer(input int hp, input int vp, input int par);
        int i, x0, x1, x2;
        i  = par ? (hp ^ 7) : hp;
        x2 = (i >> 2) & 1;
        x1 = ((i >> 1) ^ (vp >> 1)) & 1;
        x0 = (i ^ vp) & 1;
        return x0 * 16 + (i & 1) * 8 + x1 * 4 + ((i >> 1) & 1) * 2 + x2;
    endfunction

    function automatic int ref_level(input int c, input int bay, input bit den, input bit de);
        if (!de)  return 0;
        if (!den) return c / 16;
        return (c + bay + (c & 1) + (c >> 5) + (c >> 1)) / 32;
    endfunction

    // Build the expectation for the coming clock edge, then advance one cycle.
    task automatic step(input string tag);
        exp_t       e;
        logic [7:0] cur, sd;
        int         bay, lr, lg, lb;
        e.tag = tag;
        if (!rst_n) begin
            m_hist = {};
            for (int k = 0; k < PIPE_DELAY; k++) m_hist.push_back(8'h00);
            m_vsync_q = 1'b0;
            m_frame   = '0;
            e.uo      = 8'h00;
            e.frame   = '0;
        end else begin
            cur = {bus.hsync_in, bus.vsync_in, bus.display_on_in, bus.hpos_in, bus.vpos_in};
            m_hist.push_front(cur);
            sd = m_hist[PIPE_DELAY];
            void'(m_hist.pop_back());
            bay = ref_bayer(int'(sd[4:2]), int'(sd[1:0]), int'(m_frame[0]));
            lr  = ref_level(int'(bus.r_in), bay, bus.dither_en, sd[5]);
            lg  = ref_level(int'(bus.g_in), bay, bus.dither_en, sd[5]);
            lb  = ref_level(int'(bus.b_in), bay, bus.dither_en, sd[5]);
            e.uo = {sd[7], lb[0], lg[0], lr[0], sd[6], lb[1], lg[1], lr[1]};
            if (sd[6] && !m_vsync_q) m_frame = m_frame + 1'b1;
            m_vsync_q = sd[6];
            e.frame   = m_frame;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, "/uo"},    32'(bus.uo_out), 32'(e.uo));
            chk({e.tag, "/frame"}, 32'(bus.frame),  32'(e.frame));
        end
    end

    task automatic set_all(input logic v);
        bus.hsync_in      = v;
        bus.vsync_in      = v;
        bus.display_on_in = v;
        bus.hpos_in       = {3{v}};
        bus.vpos_in       = {2{v}};
        bus.r_in          = {6{v}};
        bus.g_in          = {6{v}};
        bus.b_in          = {6{v}};
        bus.dither_en     = v;
    endtask

    task automatic do_reset();
        set_all(1'b0);
        rst_n = 1'b0;
        repeat (2) step("reset");
        rst_n = 1'b1;
    endtask

    task automatic pulse_vsync();
        bus.vsync_in = 1'b1;
        step("vs_pulse");
        bus.vsync_in = 1'b0;
        repeat (PIPE_DELAY + 2) step("vs_flush");
    endtask

    initial begin
        logic [FRAME_W-1:0] f0;
        logic [7:0]         exp_lo, exp_hi;

        #1;
        // Reset with every input high
        set_all(1'b1);
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step("rst_hold");
            chk($sformatf("rst_uo%0d", k),    32'(bus.uo_out), 32'h00);
            chk($sformatf("rst_frame%0d", k), 32'(bus.frame),  32'h0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < PIPE_DELAY; k++) begin
            step("post_rst");
            chk($sformatf("post_rst_uo%0d", k),    32'(bus.uo_out), 32'h00);
            chk($sformatf("post_rst_frame%0d", k), 32'(bus.frame),  32'h0);
        end
        step("first_valid");
        chk("first_valid_uo", 32'(bus.uo_out), 32'hFF);
        chk("first_valid_frame", 32'(bus.frame), 32'h1);

        // Flat colour, truncation
        do_reset();
        bus.display_on_in = 1'b1;
        bus.dither_en     = 1'b0;
        bus.r_in = 6'h20; bus.g_in = 6'h20; bus.b_in = 6'h20;
        repeat (PIPE_DELAY + 2) step("flat");
        chk("flat_uo", 32'(bus.uo_out), 32'h07);

        // Checkerboard, both frame parities
        bus.dither_en = 1'b1;
        bus.g_in = 6'h00; bus.b_in = 6'h00;
        for (int f = 0; f < 2; f++) begin
            for (int hp = 0; hp < 2; hp++) begin
                bus.hpos_in = 3'(hp);
                repeat (PIPE_DELAY + 1) step($sformatf("chk_f%0d_h%0d", f, hp));
                chk($sformatf("checker_f%0d_h%0d", f, hp), 32'(bus.uo_out),
                    ((hp ^ f) != 0) ? 32'h01 : 32'h10);
            end
            if (f == 0) begin
                pulse_vsync();
                chk("frame_after_pulse", 32'(bus.frame), 32'h1);
            end
        end

        // Extremes over every (hpos, vpos, frame parity)
        for (int f = 0; f < 2; f++) begin
            if (m_frame[0] != 1'(f)) pulse_vsync();
            for (int hp = 0; hp < 8; hp++) begin
                for (int vp = 0; vp < 4; vp++) begin
                    bus.hpos_in = 3'(hp);
                    bus.vpos_in = 2'(vp);
                    for (int c = 0; c < 2; c++) begin
                        bus.r_in = c ? 6'h3F : 6'h00;
                        bus.g_in = bus.r_in;
                        bus.b_in = bus.r_in;
                        repeat (PIPE_DELAY + 1) step($sformatf("ext_f%0d_h%0d_v%0d_c%0d", f, hp, vp, c));
                        exp_lo = 8'h00;
                        exp_hi = 8'h77;
                        chk($sformatf("extreme_f%0d_h%0d_v%0d_c%0d", f, hp, vp, c),
                            32'(bus.uo_out), c ? 32'(exp_hi) : 32'(exp_lo));
                    end
                end
            end
        end

        // Single-cycle hsync alignment
        bus.r_in = 6'h00; bus.g_in = 6'h00; bus.b_in = 6'h00;
        bus.hsync_in = 1'b1;
        for (int k = 0; k <= PIPE_DELAY + 1; k++) begin
            step($sformatf("hs_k%0d", k));
            bus.hsync_in = 1'b0;
            chk($sformatf("hs_align_k%0d", k), 32'(bus.uo_out[7]), (k == PIPE_DELAY) ? 32'h1 : 32'h0);
        end

        // Blanking with sync passing through
        bus.display_on_in = 1'b0;
        bus.hsync_in = 1'b1;
        bus.r_in = 6'h3F; bus.g_in = 6'h3F; bus.b_in = 6'h3F;
        repeat (PIPE_DELAY + 1) step("blank");
        chk("blank_uo", 32'(bus.uo_out), 32'h80);

        // Frame counter wrap and held-vsync single increment
        do_reset();
        for (int p = 0; p < (1 << FRAME_W) + 3; p++) begin
            bus.vsync_in = 1'b1;
            step("wrap_hi");
            bus.vsync_in = 1'b0;
            step("wrap_lo");
        end
        repeat (PIPE_DELAY + 2) step("wrap_flush");
        chk("frame_wrap", 32'(bus.frame), 32'h3);
        f0 = bus.frame;
        bus.vsync_in = 1'b1;
        repeat (100) step("vs_held");
        bus.vsync_in = 1'b0;
        repeat (PIPE_DELAY + 3) step("vs_release");
        f0 = f0 + 1'b1;
        chk("frame_held_once", 32'(bus.frame), 32'(f0));

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
